// File: rtl/gate_check_pkg.sv
// Shared types and constants for the exhaustive gate sweep checkers.
package gate_check_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } gc_state_t;

  // Width of the per-vector settle counter (settle times 0..15)
  localparam int SETTLE_W = 4;

  // Index of the last input vector for an n-input gate
  function automatic int vec_last(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag; counts the hold cycles spent on
// each stimulus vector before the checker samples the gate output.
module settle_timer
  import gate_check_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority over decrement; the counter parks at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table checker: walks every input vector of a small gate,
// holds each one for SETTLE+1 cycles and compares the gate output on the
// last of them, tallying mismatches and capturing the first failing vector.
module gate_sweep_checker
  import gate_check_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]  TRUTH  = 4'b0111,
  parameter int                    SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0]     VEC_LAST = N_IN'(vec_last(N_IN));
  localparam logic [N_IN:0]       ERR_MAX  = (N_IN+1)'(1 << N_IN);
  // The SAMPLE cycle is the last hold cycle, so HOLD itself lasts SETTLE cycles
  localparam logic [SETTLE_W-1:0] RELOAD   = (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : '0;
  localparam gc_state_t           FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;

  gc_state_t       state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_vec_q, ff_vec_d;
  logic            ff_valid_q, ff_valid_d;
  logic            tmr_load;
  logic            tmr_dec;
  logic            tmr_zero;
  logic            mismatch;

  settle_timer #(
    .W(SETTLE_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state and datapath control; X/Z on the gate output is a mismatch
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_d      = err_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    mismatch   = (dut_out !== TRUTH[vec_q]);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d    = FIRST_ST;
          vec_d      = '0;
          err_d      = '0;
          ff_vec_d   = '0;
          ff_valid_d = 1'b0;
          tmr_load   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d    = ST_IDLE;
          vec_d      = '0;
          err_d      = '0;
          ff_vec_d   = '0;
          ff_valid_d = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d    = ST_IDLE;
          vec_d      = '0;
          err_d      = '0;
          ff_vec_d   = '0;
          ff_valid_d = 1'b0;
        end else begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + 1'b1;
            end
            if (!ff_valid_q) begin
              ff_vec_d   = vec_q;
              ff_valid_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            vec_d   = '0;
          end else begin
            state_d  = FIRST_ST;
            vec_d    = vec_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, stimulus and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      err_q      <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  assign stim             = vec_q;
  assign busy             = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;

endmodule
